// File: rtl/dff_chk_pkg.sv
// Shared types and constants for the flip-flop checker: FSM state encoding,
// failure cause codes and small decode helpers used by the checker and its model.
package dff_chk_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      FAIL   = 2'd3
   } state_t;

   localparam logic [1:0] FAIL_VAL  = 2'b01;
   localparam logic [1:0] FAIL_CMP  = 2'b10;
   localparam logic [1:0] FAIL_BOTH = 2'b11;

   // Clear dominates preset; otherwise the held value shows through.
   function automatic logic dff_resolve(input logic clr_n, input logic pre_n,
                                        input logic held);
      if (!clr_n)      return 1'b0;
      else if (!pre_n) return 1'b1;
      else             return held;
   endfunction

   function automatic logic is_checking(input state_t s);
      return (s == CHECK) || (s == FAIL);
   endfunction

endpackage

// File: rtl/dff_ref_model.sv
// Reference model of the observed flip-flop: tracks what Q should hold and
// produces the expected Q for the current sample edge.
module dff_ref_model
   import dff_chk_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d,
   input  logic clr_n,
   input  logic pre_n,
   output logic exp_q
);

   logic m_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q <= 1'b0;
      end else begin
         m_q <= dff_resolve(clr_n, pre_n, d);
      end
   end

   // Async clear/preset act on Q immediately, so they override the stored value.
   always_comb begin
      exp_q = dff_resolve(clr_n, pre_n, m_q);
   end

endmodule

// File: rtl/dff_checker.sv
// Flip-flop behaviour checker: compares observed Q/Q-bar against a reference model,
// counts mismatching cycles and records the first failure cause.
// Optional macro DFF_CHECKER_COMPL_EN compiles in the Q/Q-bar complement check.
module dff_checker
   import dff_chk_pkg::*;
#(
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             d,
   input  logic             clr_n,
   input  logic             pre_n,
   input  logic             q,
   input  logic             q_n,
   output logic [ERR_W-1:0] err_cnt,
   output logic             fail,
   output logic [1:0]       fail_code,
   output logic             checking,
   output state_t           state_dbg
);

   state_t           state;
   logic             exp_q;
   logic             val_err;
   logic             cmp_err;
   logic             any_err;
   logic [1:0]       err_code;
   logic [ERR_W-1:0] cnt_inc;

   dff_ref_model u_ref (
      .clk   (clk),
      .rst   (rst),
      .d     (d),
      .clr_n (clr_n),
      .pre_n (pre_n),
      .exp_q (exp_q)
   );

`ifdef DFF_CHECKER_COMPL_EN
   // Both asynchronous controls low drives Q and Q-bar to the same level legitimately.
   always_comb begin
      cmp_err = (q_n == q) && !(!clr_n && !pre_n);
   end
`else
   logic unused_q_n;
   assign unused_q_n = q_n;

   always_comb begin
      cmp_err = 1'b0;
   end
`endif

   always_comb begin
      val_err  = (q != exp_q);
      any_err  = val_err || cmp_err;
      err_code = {cmp_err, val_err};
      cnt_inc  = (&err_cnt) ? err_cnt : err_cnt + ERR_W'(1);
   end

   assign state_dbg = state;

   // Dropping en always returns to IDLE with results held for inspection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         err_cnt   <= '0;
         fail      <= 1'b0;
         fail_code <= 2'b00;
         checking  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  state     <= SETTLE;
                  checking  <= is_checking(SETTLE);
                  err_cnt   <= '0;
                  fail      <= 1'b0;
                  fail_code <= 2'b00;
               end else begin
                  checking  <= is_checking(IDLE);
               end
            end
            SETTLE: begin
               if (en) begin
                  state    <= CHECK;
                  checking <= is_checking(CHECK);
               end else begin
                  state    <= IDLE;
                  checking <= is_checking(IDLE);
               end
            end
            CHECK: begin
               if (!en) begin
                  state    <= IDLE;
                  checking <= is_checking(IDLE);
               end else if (any_err) begin
                  state     <= FAIL;
                  checking  <= is_checking(FAIL);
                  fail      <= 1'b1;
                  err_cnt   <= cnt_inc;
                  if (!fail) begin
                     fail_code <= err_code;
                  end
               end else begin
                  checking <= is_checking(CHECK);
               end
            end
            FAIL: begin
               if (!en) begin
                  state    <= IDLE;
                  checking <= is_checking(IDLE);
               end else begin
                  checking <= is_checking(FAIL);
                  if (any_err) begin
                     err_cnt <= cnt_inc;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               checking <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dff_checker.sv
// Directed bench for dff_checker: an 8-bit and a 2-bit counter instance share stimulus
// so saturation can be observed alongside the normal count.
module tb_dff_checker;
   import dff_chk_pkg::*;

   logic       clk = 1'b0;
   logic       rst, en, d, clr_n, pre_n, q, q_n;
   logic [7:0] err_cnt;
   logic       fail, checking;
   logic [1:0] fail_code;
   state_t     state_dbg;
   logic [1:0] err_cnt2;
   logic       fail2, checking2;
   logic [1:0] fail_code2;
   state_t     state_dbg2;

   int   checks = 0;
   int   errors = 0;
   logic ff = 1'b0;

`ifdef DFF_CHECKER_COMPL_EN
   localparam bit COMPL = 1'b1;
`else
   localparam bit COMPL = 1'b0;
`endif

   dff_checker #(.ERR_W(8)) dut (
      .clk(clk), .rst(rst), .en(en), .d(d), .clr_n(clr_n), .pre_n(pre_n),
      .q(q), .q_n(q_n), .err_cnt(err_cnt), .fail(fail), .fail_code(fail_code),
      .checking(checking), .state_dbg(state_dbg)
   );

   dff_checker #(.ERR_W(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .d(d), .clr_n(clr_n), .pre_n(pre_n),
      .q(q), .q_n(q_n), .err_cnt(err_cnt2), .fail(fail2), .fail_code(fail_code2),
      .checking(checking2), .state_dbg(state_dbg2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [31:0] cnt, input logic fl,
                             input logic [1:0] code, input logic chk);
      check({tag, ".err_cnt"}, 32'(err_cnt), cnt);
      check({tag, ".fail"}, 32'(fail), 32'(fl));
      check({tag, ".fail_code"}, 32'(fail_code), 32'(code));
      check({tag, ".checking"}, 32'(checking), 32'(chk));
   endtask

   // Behaves like a healthy flip-flop: Q reflects async controls or the last captured D.
   task automatic ideal(input logic dv, input logic cv, input logic pv);
      d     = dv;
      clr_n = cv;
      pre_n = pv;
      q     = !cv ? 1'b0 : (!pv ? 1'b1 : ff);
      q_n   = ~q;
   endtask

   task automatic tick();
      logic nxt;
      nxt = !clr_n ? 1'b0 : (!pre_n ? 1'b1 : d);
      @(posedge clk);
      ff = rst ? 1'b0 : nxt;
      #1;
   endtask

   task automatic bad_q();
      q   = ~ff;
      q_n = ff;
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      ideal(1'b0, 1'b1, 1'b1);
      #1;
      check_outs("reset", 0, 1'b0, 2'b00, 1'b0);
      check("reset.state", 32'(state_dbg), 32'(IDLE));
      tick();
      tick();
      rst = 1'b0;
      tick();
      check_outs("post_reset", 0, 1'b0, 2'b00, 1'b0);

      en = 1'b1;
      tick();
      check("enter.state", 32'(state_dbg), 32'(SETTLE));
      check("enter.checking", 32'(checking), 32'(1'b0));
      tick();
      check("settle.state", 32'(state_dbg), 32'(CHECK));
      check("settle.checking", 32'(checking), 32'(1'b1));

      for (int i = 0; i < 8; i++) begin
         ideal(logic'(i % 2 == 0), 1'b1, 1'b1);
         tick();
      end
      check_outs("toggle", 0, 1'b0, 2'b00, 1'b1);

      for (int i = 0; i < 3; i++) begin
         ideal(1'b1, 1'b0, 1'b1);
         check("clear.q_drive", 32'(q), 32'(1'b0));
         tick();
         check("clear.err_cnt", 32'(err_cnt), 0);
      end
      ideal(1'b0, 1'b1, 1'b0);
      tick();
      check("preset.err_cnt", 32'(err_cnt), 0);
      d = 1'b1; clr_n = 1'b0; pre_n = 1'b0; q = 1'b0; q_n = 1'b0;
      tick();
      check("both_low.err_cnt", 32'(err_cnt), 0);
      ideal(1'b0, 1'b1, 1'b1);
      tick();
      check_outs("idle_ok", 0, 1'b0, 2'b00, 1'b1);

      d = 1'b0; q = 1'b1; q_n = 1'b0;
      tick();
      check_outs("stuck1.first", 1, 1'b1, FAIL_VAL, 1'b1);
      check("stuck1.state", 32'(state_dbg), 32'(FAIL));
      for (int i = 0; i < 3; i++) tick();
      check_outs("stuck1.four", 4, 1'b1, FAIL_VAL, 1'b1);

      d = 1'b0; clr_n = 1'b0; q = 1'b1; q_n = 1'b0;
      tick();
      check("clear_bad.err_cnt", 32'(err_cnt), 5);
      ideal(1'b0, 1'b1, 1'b1);
      q_n = q;
      tick();
      check_outs("fail_cmp", COMPL ? 6 : 5, 1'b1, FAIL_VAL, 1'b1);
      ideal(1'b0, 1'b1, 1'b1);
      tick();
      check("fail_clean.err_cnt", 32'(err_cnt), COMPL ? 6 : 5);

      en = 1'b0;
      bad_q();
      tick();
      check_outs("en_off", COMPL ? 6 : 5, 1'b1, FAIL_VAL, 1'b0);
      check("en_off.state", 32'(state_dbg), 32'(IDLE));
      tick();
      check("idle_bad.err_cnt", 32'(err_cnt), COMPL ? 6 : 5);
      en = 1'b1;
      tick();
      check_outs("reenter", 0, 1'b0, 2'b00, 1'b0);
      bad_q();
      tick();
      check("settle_bad.err_cnt", 32'(err_cnt), 0);
      check("settle_bad.state", 32'(state_dbg), 32'(CHECK));

      for (int i = 0; i < 2; i++) begin
         ideal(logic'(i), 1'b1, 1'b1);
         q_n = q;
         tick();
      end
      if (COMPL) check_outs("cmp_only", 2, 1'b1, FAIL_CMP, 1'b1);
      else       check_outs("cmp_only", 0, 1'b0, 2'b00, 1'b1);

      en = 1'b0; ideal(1'b0, 1'b1, 1'b1); tick();
      en = 1'b1; tick(); tick();
      q   = ~ff;
      q_n = q;
      tick();
      check_outs("both_err", 1, 1'b1, COMPL ? FAIL_BOTH : FAIL_VAL, 1'b1);

      en = 1'b0; ideal(1'b0, 1'b1, 1'b1); tick();
      en = 1'b1; tick(); tick();
      for (int i = 0; i < 6; i++) begin
         bad_q();
         tick();
         if (i == 2) check("sat.three", 32'(err_cnt2), 3);
      end
      check("sat.held", 32'(err_cnt2), 3);
      check("sat.wide", 32'(err_cnt), 6);
      check("sat.fail", 32'(fail2), 32'(1'b1));
      en = 1'b0; ideal(1'b0, 1'b1, 1'b1); tick();
      en = 1'b1; tick();
      ideal(1'b0, 1'b1, 1'b1);
      tick();
      check("sat_clr.err_cnt", 32'(err_cnt2), 0);
      check("sat_clr.fail", 32'(fail2), 32'(1'b0));
      check("sat_clr.state", 32'(state_dbg2), 32'(CHECK));

      for (int i = 0; i < 5; i++) begin
         bad_q();
         tick();
      end
      check("pre_rst.err_cnt", 32'(err_cnt), 5);
      check("pre_rst.state", 32'(state_dbg), 32'(FAIL));
      #2;
      rst = 1'b1;
      ff  = 1'b0;
      #1;
      check_outs("mid_rst", 0, 1'b0, 2'b00, 1'b0);
      check("mid_rst.state", 32'(state_dbg), 32'(IDLE));
      check("mid_rst.err_cnt2", 32'(err_cnt2), 0);
      #2;
      rst = 1'b0;
      ideal(1'b0, 1'b1, 1'b1);
      tick();
      check("rst_reenter.state", 32'(state_dbg), 32'(SETTLE));
      tick();
      check("rst_settle.state", 32'(state_dbg), 32'(CHECK));
      bad_q();
      tick();
      check_outs("rst_after", 1, 1'b1, FAIL_VAL, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dff_checker.md
DFF_CHECKER -- requirements
Module: dff_checker

Interface
REQ-001 Parameter ERR_W, default 8: width of the mismatch counter.
REQ-002 Port clk  input  1: sole clock; all sampling on rising edge.
REQ-003 Port rst  input  1: reset, asynchronous, active-high.
REQ-004 Port en  input  1: checking enable; level-sensitive.
REQ-005 Port d  input  1: D value driven into the observed flip-flop.
REQ-006 Port clr_n  input  1: active-low asynchronous clear seen by the observed flip-flop.
REQ-007 Port pre_n  input  1: active-low asynchronous preset seen by the observed flip-flop.
REQ-008 Port q  input  1: observed flip-flop Q.
REQ-009 Port q_n  input  1: observed flip-flop Q-bar.
REQ-010 Port err_cnt  output  ERR_W: count of mismatching check cycles.
REQ-011 Port fail  output  1: sticky flag, high after the first mismatch.
REQ-012 Port fail_code  output  2: cause of the first mismatch; bit0 = Q value error, bit1 = complement error.
REQ-013 Port checking  output  1: high while in state CHECK or FAIL.

Function
REQ-014 Reference model register m_q SHALL load on every rising clk edge: 0 if clr_n=0, else 1 if pre_n=0, else d.
REQ-015 Clear SHALL take priority over preset, in the model and in the expected value.
REQ-016 Expected Q at a sample edge SHALL be: 0 if clr_n=0, else 1 if pre_n=0, else m_q as loaded on the previous edge.
REQ-017 The value check SHALL flag an error when q differs from expected Q.
REQ-018 The complement check SHALL flag an error when q_n equals q.
REQ-019 The complement check SHALL be waived in any cycle where clr_n=0 and pre_n=0 together.
REQ-020 FSM states SHALL be IDLE, SETTLE, CHECK and FAIL.
REQ-021 IDLE->SETTLE when en=1; on this transition err_cnt, fail and fail_code SHALL clear.
REQ-022 SETTLE->CHECK after exactly one cycle; no comparison SHALL occur in SETTLE; m_q still loads.
REQ-023 In CHECK, any flagged error SHALL: transition to FAIL, set fail, capture fail_code, increment err_cnt.
REQ-024 In FAIL, checks continue; each erroneous cycle SHALL increment err_cnt; fail_code SHALL hold its first value.
REQ-025 err_cnt SHALL saturate at 2^ERR_W-1 and never wrap.
REQ-026 en=0 in any state SHALL go to IDLE next cycle; err_cnt, fail and fail_code SHALL hold.
REQ-027 A value error and a complement error in the same cycle SHALL count once, with fail_code=2'b11 if it is the first failure.
REQ-028 Results SHALL be registered: an error sampled at edge N is visible on the outputs after edge N.

Reset
REQ-029 rst=1 SHALL immediately force: state IDLE, m_q=0, err_cnt=0, fail=0, fail_code=2'b00, checking=0.
REQ-030 rst asserted mid-check SHALL abandon the check; after release the FSM SHALL re-enter via SETTLE.

Configuration
REQ-031 Macro DFF_CHECKER_COMPL_EN: when defined, the complement check (REQ-018/019) SHALL be compiled in.
REQ-032 Without DFF_CHECKER_COMPL_EN, q_n SHALL be ignored and fail_code bit1 SHALL be constant 0.

Structure
REQ-033 Package dff_chk_pkg SHALL hold the FSM state type and the constants FAIL_VAL=2'b01, FAIL_CMP=2'b10 and FAIL_BOTH=2'b11.
REQ-034 Sub-module dff_ref_model SHALL contain m_q and the expected-Q logic (REQ-014..016); dff_checker SHALL hold the FSM, counter and capture logic.

Verification
REQ-035 Ideal DFF, d toggled 1,0,1,0 over 8 cycles with clr_n=pre_n=1, en=1 -> err_cnt=0, fail=0.
REQ-036 clr_n=0 for 3 cycles while d=1, ideal DUT -> q expected 0 throughout, err_cnt=0.
REQ-037 q stuck at 1, d=0 for 4 check cycles -> fail=1 one cycle after the first bad edge, fail_code=01, err_cnt=4.
REQ-038 q_n=q for 2 cycles with the macro defined -> fail_code=10, err_cnt=2; same stimulus without the macro -> err_cnt=0.
REQ-039 ERR_W=2, 6 consecutive errors -> err_cnt saturates at 3; en low then high -> err_cnt=0 and fail=0 after SETTLE.
REQ-040 rst pulsed in FAIL with err_cnt=5 -> all outputs 0 immediately; a further error after release and SETTLE -> err_cnt=1.
